// File: rtl/dds_phase_accum.sv
// Phase accumulator for the DDS: adds the tuning word each active cycle and
// emits an offset, truncated phase word with an overflow flag, in continuous or burst mode.
module dds_phase_accum #(
    parameter int ACC_WIDTH   = 24,
    parameter int PHASE_WIDTH = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   hold,
    input  logic                   mode,
    input  logic [CNT_WIDTH-1:0]   burst_len,
    input  logic [ACC_WIDTH-1:0]   ftw,
    input  logic [PHASE_WIDTH-1:0] pofs,
    output logic [PHASE_WIDTH-1:0] phase_out,
    output logic                   phase_vld,
    output logic                   wrap,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_nxt;
    logic [ACC_WIDTH-1:0] acc;
    logic                 carry_q;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] len_q;
    logic                 mode_q;
    logic [ACC_WIDTH:0]   sum;
    logic                 accept;
    logic                 active;
    logic                 last;

    assign sum  = {1'b0, acc} + {1'b0, ftw};
    assign busy = (state == RUN);

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        active    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                // stop wins over start; a zero-length burst is not a valid request
                if (start && !stop && (!mode || (burst_len != '0))) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (!hold) begin
                    active = 1'b1;
                    last   = mode_q && (cnt == len_q - CNT_WIDTH'(1));
                    if (last) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            acc       <= '0;
            carry_q   <= 1'b0;
            cnt       <= '0;
            len_q     <= '0;
            mode_q    <= 1'b0;
            phase_out <= '0;
            phase_vld <= 1'b0;
            wrap      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase_vld <= active;
            wrap      <= active & carry_q;
            done      <= last;
            if (accept) begin
                acc     <= '0;
                carry_q <= 1'b0;
                cnt     <= '0;
                mode_q  <= mode;
                len_q   <= burst_len;
            end
            if (active) begin
                // output stage sees the accumulator value from before this add
                phase_out <= acc[ACC_WIDTH-1 -: PHASE_WIDTH] + pofs;
                acc       <= sum[ACC_WIDTH-1:0];
                carry_q   <= sum[ACC_WIDTH];
                cnt       <= cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule
